// File: rtl/vga_sync_receiver_if.sv
// Bus bundle for vga_sync_receiver: sync/colour inputs from the source and the
// recovered pixel stream, error flags and checksum back to the consumer.
interface vga_sync_receiver_if;
    logic        enable;
    logic        hs;
    logic        vs;
    logic [1:0]  red_pixel_in;
    logic [1:0]  green_pixel_in;
    logic [1:0]  blue_pixel_in;
    logic        err_clr;
    // pixel_valid qualifies x/y/colour for exactly one cycle; there is no back-pressure.
    logic        pixel_valid;
    logic [9:0]  x;
    logic [9:0]  y;
    logic [1:0]  red_pixel_out;
    logic [1:0]  green_pixel_out;
    logic [1:0]  blue_pixel_out;
    logic        frame_start;
    logic        locked;
    logic        hs_err;
    logic        vs_err;
    logic [15:0] frame_sum;
    logic        frame_sum_valid;
    logic [1:0]  fsm_state;

    modport master (
        output enable, hs, vs, red_pixel_in, green_pixel_in, blue_pixel_in, err_clr,
        input  pixel_valid, x, y, red_pixel_out, green_pixel_out, blue_pixel_out,
        input  frame_start, locked, hs_err, vs_err, frame_sum, frame_sum_valid, fsm_state
    );

    modport slave (
        input  enable, hs, vs, red_pixel_in, green_pixel_in, blue_pixel_in, err_clr,
        output pixel_valid, x, y, red_pixel_out, green_pixel_out, blue_pixel_out,
        output frame_start, locked, hs_err, vs_err, frame_sum, frame_sum_valid, fsm_state
    );
endinterface

// File: rtl/vga_sync_receiver.sv
// VGA sync receiver: locks onto hs/vs timing and emits active-area pixels with coordinates.
// Optional per-frame checksum enabled by defining VGA_RX_CHECKSUM_EN.
module vga_sync_receiver #(
    parameter int H_VISIBLE = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33
) (
    input logic               clk,
    input logic               rst_n,
    vga_sync_receiver_if.slave bus
);
    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
    localparam logic [9:0] H_END  = 10'(H_TOTAL);
    localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
    localparam logic [9:0] V_END  = 10'(V_TOTAL);
    localparam logic [9:0] H_ACT0 = 10'(H_SYNC + H_BACK);
    localparam logic [9:0] H_ACT1 = 10'(H_SYNC + H_BACK + H_VISIBLE);
    localparam logic [9:0] V_ACT0 = 10'(V_SYNC + V_BACK);
    localparam logic [9:0] V_ACT1 = 10'(V_SYNC + V_BACK + V_VISIBLE);

    typedef enum logic [1:0] {SEARCH, MEASURE, ALIGN, LOCKED} state_t;

    state_t      state_q, state_d;
    logic        hs_q, hs_prev_q, vs_q, vs_prev_q, en_q, clr_q;
    logic [5:0]  rgb_q;
    logic [9:0]  hcnt_q, hcnt, vcnt_q, vcnt;
    logic        vs_arm_q, vs_arm_d;
    logic        hs_fall, vs_fall, vs_load;
    logic        hs_evt, vs_evt;
    logic        hs_err_q, hs_err_d, vs_err_q, vs_err_d;
    logic        valid_q, valid_d, fs_q, fs_d;
    logic [9:0]  x_q, x_d, y_q, y_d;
    logic [5:0]  rgb_out_q, rgb_out_d;

    assign hs_fall = hs_prev_q & ~hs_q;
    assign vs_fall = vs_prev_q & ~vs_q;
    assign vs_load = hs_fall & (vs_arm_q | vs_fall);

    // hcnt/vcnt are the counts for the current stage-1 cycle; the _q copies are the prior cycle.
    always_comb begin
        hcnt = (hcnt_q == 10'h3FF) ? hcnt_q : hcnt_q + 10'd1;
        if (hs_fall) hcnt = '0;
        vcnt = vcnt_q;
        if (vs_load) vcnt = '0;
        else if (hs_fall && vcnt_q != 10'h3FF) vcnt = vcnt_q + 10'd1;
        vs_arm_d = vs_arm_q;
        if (vs_load) vs_arm_d = 1'b0;
        else if (vs_fall) vs_arm_d = 1'b1;
    end

    always_comb begin
        hs_evt = 1'b0;
        vs_evt = 1'b0;
        if (en_q && state_q == LOCKED) begin
            hs_evt = (hs_fall && hcnt_q != H_LAST) || (hcnt == H_END);
            vs_evt = (vs_load && vcnt_q != V_LAST) || (vcnt == V_END);
        end
        state_d = state_q;
        case (state_q)
            SEARCH:  if (hs_fall) state_d = MEASURE;
            MEASURE: if (hs_fall) state_d = (hcnt_q == H_LAST) ? ALIGN : SEARCH;
            ALIGN:   if (vs_load) state_d = LOCKED;
            LOCKED:  if (hs_evt || vs_evt) state_d = SEARCH;
            default: state_d = SEARCH;
        endcase
        if (!en_q) state_d = SEARCH;
    end

    // Set wins over clear; both are frozen while disabled.
    always_comb begin
        hs_err_d = hs_err_q;
        vs_err_d = vs_err_q;
        if (en_q && clr_q) begin
            hs_err_d = 1'b0;
            vs_err_d = 1'b0;
        end
        if (hs_evt) hs_err_d = 1'b1;
        if (vs_evt) vs_err_d = 1'b1;
    end

    always_comb begin
        valid_d   = (state_d == LOCKED) && (hcnt >= H_ACT0) && (hcnt < H_ACT1)
                    && (vcnt >= V_ACT0) && (vcnt < V_ACT1);
        x_d       = valid_d ? hcnt - H_ACT0 : '0;
        y_d       = valid_d ? vcnt - V_ACT0 : '0;
        rgb_out_d = valid_d ? rgb_q : '0;
        fs_d      = valid_d && (x_d == '0) && (y_d == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hs_q      <= 1'b0;
            hs_prev_q <= 1'b0;
            vs_q      <= 1'b0;
            vs_prev_q <= 1'b0;
            en_q      <= 1'b0;
            clr_q     <= 1'b0;
            rgb_q     <= '0;
            hcnt_q    <= '0;
            vcnt_q    <= '0;
            vs_arm_q  <= 1'b0;
            state_q   <= SEARCH;
            hs_err_q  <= 1'b0;
            vs_err_q  <= 1'b0;
            valid_q   <= 1'b0;
            x_q       <= '0;
            y_q       <= '0;
            rgb_out_q <= '0;
            fs_q      <= 1'b0;
        end else begin
            hs_q      <= bus.hs;
            hs_prev_q <= hs_q;
            vs_q      <= bus.vs;
            vs_prev_q <= vs_q;
            en_q      <= bus.enable;
            clr_q     <= bus.err_clr;
            rgb_q     <= {bus.red_pixel_in, bus.green_pixel_in, bus.blue_pixel_in};
            hcnt_q    <= hcnt;
            vcnt_q    <= vcnt;
            vs_arm_q  <= vs_arm_d;
            state_q   <= state_d;
            hs_err_q  <= hs_err_d;
            vs_err_q  <= vs_err_d;
            valid_q   <= valid_d;
            x_q       <= x_d;
            y_q       <= y_d;
            rgb_out_q <= rgb_out_d;
            fs_q      <= fs_d;
        end
    end

`ifdef VGA_RX_CHECKSUM_EN
    localparam logic [9:0] X_LAST = 10'(H_VISIBLE - 1);
    localparam logic [9:0] Y_LAST = 10'(V_VISIBLE - 1);
    logic [15:0] acc_q, acc_d, sum_q;
    logic        sum_vld_q, frame_ok_q, frame_ok_d, last_px;

    // frame_ok tracks that the current frame has been locked continuously since (0,0).
    always_comb begin
        acc_d      = (fs_q ? 16'd0 : acc_q) + (valid_q ? {10'd0, rgb_out_q} : 16'd0);
        frame_ok_d = fs_q || (frame_ok_q && state_q == LOCKED);
        last_px    = valid_q && (x_q == X_LAST) && (y_q == Y_LAST);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q      <= '0;
            sum_q      <= '0;
            sum_vld_q  <= 1'b0;
            frame_ok_q <= 1'b0;
        end else begin
            acc_q      <= acc_d;
            frame_ok_q <= frame_ok_d;
            sum_vld_q  <= last_px && frame_ok_d;
            if (last_px && frame_ok_d) sum_q <= acc_d;
        end
    end

    assign bus.frame_sum       = sum_q;
    assign bus.frame_sum_valid = sum_vld_q;
`else
    assign bus.frame_sum       = '0;
    assign bus.frame_sum_valid = 1'b0;
`endif

    assign bus.pixel_valid     = valid_q;
    assign bus.x               = x_q;
    assign bus.y               = y_q;
    assign bus.red_pixel_out   = rgb_out_q[5:4];
    assign bus.green_pixel_out = rgb_out_q[3:2];
    assign bus.blue_pixel_out  = rgb_out_q[1:0];
    assign bus.frame_start     = fs_q;
    assign bus.locked          = (state_q == LOCKED);
    assign bus.hs_err          = hs_err_q;
    assign bus.vs_err          = vs_err_q;
    assign bus.fsm_state       = state_q;
endmodule

// File: doc/vga_sync_receiver.md
VGA_SYNC_RECEIVER -- requirements
Module: vga_sync_receiver

Interface
REQ-001 Parameters SHALL be H_VISIBLE 640, H_FRONT 16, H_SYNC 96, H_BACK 48, V_VISIBLE 480, V_FRONT 10, V_SYNC 2 and V_BACK 33, with totals of 800 clocks per line and 525 lines per frame.
REQ-002 clk  in  1  pixel clock, 25 MHz; all logic on its rising edge.
REQ-003 rst_n  in  1  asynchronous, active-low reset.
REQ-004 enable  in  1  receiver enable; low forces SEARCH and deasserts pixel_valid.
REQ-005 hs, vs  in  1 each  sync inputs, active-low pulses.
REQ-006 red_pixel_in, green_pixel_in, blue_pixel_in  in  2 each  incoming colour.
REQ-007 err_clr  in  1  single-cycle pulse that clears the sticky error flags.
REQ-008 pixel_valid  out  1  high for each active-area pixel while LOCKED.
REQ-009 x, y  out  10 each  coordinate of the current output pixel: x 0..639, y 0..479.
REQ-010 red_pixel_out, green_pixel_out, blue_pixel_out  out  2 each  captured colour, zero whenever pixel_valid is low.
REQ-011 frame_start  out  1  one-cycle pulse coinciding with pixel (0,0).
REQ-012 locked  out  1  high in the LOCKED state.
REQ-013 hs_err, vs_err  out  1 each  sticky timing-error flags.
REQ-014 frame_sum  out  16  per-frame pixel checksum (see Configuration).
REQ-015 frame_sum_valid  out  1  one-cycle pulse when frame_sum updates.

Function
REQ-016 All inputs except rst_n SHALL be registered once, and edge detection SHALL operate on the registered copies.
REQ-017 hcnt (10-bit) SHALL be 0 on the cycle the registered hs first reads 0 after reading 1, and SHALL otherwise increment by 1, saturating at 1023.
REQ-018 A vs falling edge SHALL arm a flag; on the next hs falling edge (or the same cycle), vcnt SHALL be set to 0 and the flag SHALL clear.
REQ-019 Every other hs falling edge SHALL increment vcnt, and vcnt SHALL saturate at 1023.
REQ-020 The FSM SHALL have the states SEARCH, MEASURE, ALIGN and LOCKED.
REQ-021 SEARCH SHALL move to MEASURE on an hs falling edge.
REQ-022 MEASURE SHALL move to ALIGN on an hs falling edge with the prior hcnt equal to 799; any other period SHALL return it to SEARCH.
REQ-023 ALIGN SHALL move to LOCKED when vcnt is set to 0 per REQ-018.
REQ-024 LOCKED: an hs falling edge with prior hcnt not equal to 799, or hcnt reaching 800 without an edge, SHALL set hs_err and move the FSM to SEARCH.
REQ-025 LOCKED: vcnt being set to 0 while the prior vcnt is not 524, or vcnt reaching 525, SHALL set vs_err and move the FSM to SEARCH.
REQ-026 The active area SHALL be hcnt 144..783 with vcnt 35..514, giving x = hcnt-144 and y = vcnt-35.
REQ-027 Outputs SHALL be registered with a fixed latency of 2 clocks from the input pins to pixel_valid, x, y and colour.
REQ-028 pixel_valid SHALL fall in the same cycle that locked falls.
REQ-029 If err_clr coincides with a new error, the error flag SHALL remain set, because set has priority over clear.
REQ-030 If enable is low, the FSM SHALL be held in SEARCH, and the error flags SHALL hold their values.

Reset
REQ-031 While rst_n is low, the FSM SHALL be in SEARCH, all counters and flags SHALL be 0, every output SHALL be 0, and frame_sum SHALL be 0.
REQ-032 A reset asserted mid-frame SHALL take effect immediately, and relock after release SHALL require the full sequence SEARCH, MEASURE, ALIGN, LOCKED.

Configuration
REQ-033 With VGA_RX_CHECKSUM_EN defined, the block SHALL accumulate the 16-bit wrapping sum of {red,green,blue}, zero-extended from 6 bits, over all valid pixels of a frame.
REQ-034 With VGA_RX_CHECKSUM_EN defined, frame_sum SHALL be loaded one cycle after pixel (639,479), with frame_sum_valid pulsing in that same cycle, and the accumulator SHALL be reset at frame_start.
REQ-035 With VGA_RX_CHECKSUM_EN defined, a frame broken by an error SHALL produce no frame_sum_valid pulse.
REQ-036 Without VGA_RX_CHECKSUM_EN, frame_sum and frame_sum_valid SHALL be tied to 0, no accumulator SHALL be present, and the ports SHALL remain.

Verification
REQ-037 Drive a nominal 640x480 stream of constant colour 2'b11 on every channel for 2 frames -> locked rises at the first vs-aligned line, 307200 valid pixels are seen in frame 2, and frame_start pulses once per frame.
REQ-038 Drive a horizontal ramp where the colour equals x[1:0] -> the output colour at x=5 is 2'b01, and the latency from the pins is exactly 2 clocks.
REQ-039 Shorten one line to 799 clocks mid-frame -> hs_err is set, locked and pixel_valid fall, and after 2 clean lines plus a vs edge the block relocks.
REQ-040 Use frames of 526 lines -> vs_err is set; then pulse err_clr -> vs_err clears; with err_clr coinciding with a new error -> vs_err stays set.
REQ-041 Assert rst_n low for 3 clocks during active video -> all outputs read 0, and the block relocks one frame after release.
REQ-042 With VGA_RX_CHECKSUM_EN defined, send an all-2'b01 frame (pixel value 6'b010101 = 21) -> frame_sum = (307200*21) mod 65536 = 28672.
